// File: rtl/timer_compare.sv
// timer_compare
//   Compare stage of the 64-bit timer. Holds a 64-bit compare value split
//   over two 32-bit registers and raises a sticky interrupt status when the
//   live count equals it. Status is masked by an enable bit to form the
//   interrupt line to the core interrupt controller. Readback muxing is done
//   in the APB slave; this block only exposes the register contents.
//
//   Ports:
//     clk      in   system clock, all state on rising edge
//     rst_n    in   asynchronous active-low reset
//     addr     in   [31:0] register byte address (full-width decode)
//     wr_en    in   register write strobe
//     wdata    in   [31:0] register write data
//     cnt      in   [63:0] live count from the counter stage
//     tcmp0    out  [31:0] compare value [31:0]
//     tcmp1    out  [31:0] compare value [63:32]
//     tier     out  [31:0] {31'b0, int_en}
//     tisr     out  [31:0] {31'b0, int_st}  (write-1-to-clear)
//     tim_int  out  interrupt request = int_st & int_en
//
//   Build option:
//     TIMER_CMP_EDGE_EN  defined   -> status sets on rising edge of match only
//                        undefined -> status sets every cycle match is high
module timer_compare #(
    parameter logic [31:0] TCMP0_ADDR = 32'h0000_000C,
    parameter logic [31:0] TCMP1_ADDR = 32'h0000_0010,
    parameter logic [31:0] TIER_ADDR  = 32'h0000_0014,
    parameter logic [31:0] TISR_ADDR  = 32'h0000_0018,
    parameter logic [31:0] CMP_RST    = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    input  logic [63:0] cnt,
    output logic [31:0] tcmp0,
    output logic [31:0] tcmp1,
    output logic [31:0] tier,
    output logic [31:0] tisr,
    output logic        tim_int
);

    logic int_en;
    logic int_st;
    logic match;
    logic set_st;
    logic wr_tcmp0;
    logic wr_tcmp1;
    logic wr_tier;
    logic clr_st;

    assign wr_tcmp0 = wr_en && (addr == TCMP0_ADDR);
    assign wr_tcmp1 = wr_en && (addr == TCMP1_ADDR);
    assign wr_tier  = wr_en && (addr == TIER_ADDR);
    assign clr_st   = wr_en && (addr == TISR_ADDR) && wdata[0];

    // Uses the registered (pre-write) compare value, so a compare write in
    // the same cycle only takes effect from the next cycle.
    assign match = (cnt == {tcmp1, tcmp0});

`ifdef TIMER_CMP_EDGE_EN
    // History resets to 1 so a count already equal to the reset compare
    // value does not look like a fresh edge when reset is released.
    logic match_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_d <= 1'b1;
        end else begin
            match_d <= match;
        end
    end

    assign set_st = match & ~match_d;
`else
    assign set_st = match;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcmp0  <= CMP_RST;
            tcmp1  <= CMP_RST;
            int_en <= 1'b0;
            int_st <= 1'b0;
        end else begin
            if (wr_tcmp0) begin
                tcmp0 <= wdata;
            end
            if (wr_tcmp1) begin
                tcmp1 <= wdata;
            end
            if (wr_tier) begin
                int_en <= wdata[0];
            end
            // Set wins over a simultaneous write-1-to-clear.
            if (set_st) begin
                int_st <= 1'b1;
            end else if (clr_st) begin
                int_st <= 1'b0;
            end
        end
    end

    assign tier    = {31'b0, int_en};
    assign tisr    = {31'b0, int_st};
    assign tim_int = int_st & int_en;

endmodule
